// File: rtl/sprite_loader.sv
// sprite_loader: double-buffered 8x8 sprite bitmap, loaded one row per valid/ready beat, read through {y,x}.
// Define SPRITE_MIRROR_EN to add i_flip_x, which mirrors the read port horizontally.
module sprite_loader #(
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic                i_row_valid,
    input  logic [SPRITE_W-1:0] i_row_data,
    output logic                o_row_ready,
    input  logic                i_frame_sync,
    output logic                o_busy,
    output logic                o_swapped,
    input  logic [5:0]          i_rom_counter,
`ifdef SPRITE_MIRROR_EN
    input  logic                i_flip_x,
`endif
    output logic                o_sprite_color
);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    state_t              state;
    logic                active_bank;
    logic [2:0]          row_idx;
    logic [SPRITE_W-1:0] bank [2][SPRITE_H];
    logic [SPRITE_W-1:0] active_row;
    logic [2:0]          pix_x;

    function automatic logic [SPRITE_W-1:0] default_row(input logic [2:0] r);
        case (r)
            3'd0:    default_row = 8'b0111_0000;
            3'd1:    default_row = 8'b1111_0000;
            3'd2:    default_row = 8'b0011_0000;
            3'd3:    default_row = 8'b0011_1001;
            3'd4:    default_row = 8'b0011_1111;
            3'd5:    default_row = 8'b0001_1110;
            3'd6:    default_row = 8'b0001_0100;
            default: default_row = 8'b0001_0100;
        endcase
    endfunction

    // Writes always target the inactive bank, so the display only ever sees a complete sprite.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < SPRITE_H; r++) begin
                    bank[b][r] <= default_row(3'(r));
                end
            end
            state       <= IDLE;
            active_bank <= 1'b0;
            row_idx     <= 3'd0;
            o_row_ready <= 1'b0;
            o_busy      <= 1'b0;
            o_swapped   <= 1'b0;
        end else begin
            o_swapped <= 1'b0;
            if (i_start) begin
                state       <= LOAD;
                row_idx     <= 3'd0;
                o_row_ready <= 1'b1;
                o_busy      <= 1'b1;
            end else begin
                case (state)
                    LOAD: begin
                        if (i_row_valid && o_row_ready) begin
                            bank[~active_bank][row_idx] <= i_row_data;
                            row_idx <= row_idx + 3'd1;
                            if (row_idx == 3'(SPRITE_H - 1)) begin
                                state       <= COMMIT;
                                o_row_ready <= 1'b0;
                            end
                        end
                    end
                    COMMIT: begin
                        if (i_frame_sync) begin
                            active_bank <= ~active_bank;
                            state       <= IDLE;
                            o_busy      <= 1'b0;
                            o_swapped   <= 1'b1;
                        end
                    end
                    default: begin
                        o_row_ready <= 1'b0;
                        o_busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign active_row = bank[active_bank][i_rom_counter[5:3]];

`ifdef SPRITE_MIRROR_EN
    assign pix_x = i_flip_x ? (3'd7 - i_rom_counter[2:0]) : i_rom_counter[2:0];
`else
    assign pix_x = i_rom_counter[2:0];
`endif

    assign o_sprite_color = active_row[pix_x];

endmodule

// File: tb/tb_sprite_loader.sv
// tb_sprite_loader: directed and randomized checks of sprite_loader against a row-list reference model.
// Define SPRITE_MIRROR_EN to also exercise the horizontal mirror read.
module tb_sprite_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       row_valid;
    logic [7:0] row_data;
    logic       row_ready;
    logic       frame_sync;
    logic       busy;
    logic       swapped;
    logic [5:0] rom_counter;
    logic       sprite_color;
`ifdef SPRITE_MIRROR_EN
    logic       flip_x;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] default_rows [8] = '{8'h70, 8'hF0, 8'h30, 8'h39, 8'h3F, 8'h1E, 8'h14, 8'h14};

    // Reference model: two row lists, which one is shown, and how far a load has progressed.
    logic [7:0] mdl_bank [2][8];
    int         mdl_active;
    bit         mdl_loading;
    int         mdl_rows;
    bit         mdl_armed;
    bit         mdl_swapped;
    bit         mdl_flip;

    always #50 clk = ~clk;

    sprite_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (start),
        .i_row_valid    (row_valid),
        .i_row_data     (row_data),
        .o_row_ready    (row_ready),
        .i_frame_sync   (frame_sync),
        .o_busy         (busy),
        .o_swapped      (swapped),
        .i_rom_counter  (rom_counter),
`ifdef SPRITE_MIRROR_EN
        .i_flip_x       (flip_x),
`endif
        .o_sprite_color (sprite_color)
    );

    task automatic modelReset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 8; r++)
                mdl_bank[b][r] = default_rows[r];
        mdl_active  = 0;
        mdl_loading = 0;
        mdl_rows    = 0;
        mdl_armed   = 0;
        mdl_swapped = 0;
    endtask

    function automatic logic modelPixel(input int addr);
        int y;
        int x;
        y = addr / 8;
        x = addr % 8;
        if (mdl_flip) x = 7 - x;
        return mdl_bank[mdl_active][y][x];
    endfunction

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare just after it.
    task automatic applyStimulus(input bit st, input bit vld, input logic [7:0] data, input bit sync);
        start       = st;
        row_valid   = vld;
        row_data    = data;
        frame_sync  = sync;
        rom_counter = 6'($urandom_range(0, 63));
        @(posedge clk);
        mdl_swapped = 0;
        if (st) begin
            mdl_loading = 1;
            mdl_rows    = 0;
            mdl_armed   = 0;
        end else if (mdl_loading && vld) begin
            mdl_bank[1 - mdl_active][mdl_rows] = data;
            mdl_rows++;
            if (mdl_rows == 8) begin
                mdl_loading = 0;
                mdl_armed   = 1;
            end
        end else if (mdl_armed && sync) begin
            mdl_active  = 1 - mdl_active;
            mdl_armed   = 0;
            mdl_swapped = 1;
        end
        #1;
        checkOutput("row_ready", row_ready, mdl_loading);
        checkOutput("busy", busy, mdl_loading || mdl_armed);
        checkOutput("swapped", swapped, mdl_swapped);
        checkOutput("pixel", sprite_color, modelPixel(int'(rom_counter)));
    endtask

    task automatic sweepCheck(input string tag);
        start      = 1'b0;
        row_valid  = 1'b0;
        frame_sync = 1'b0;
        for (int a = 0; a < 64; a++) begin
            rom_counter = 6'(a);
            #1;
            checkOutput(tag, sprite_color, modelPixel(a));
        end
    endtask

    task automatic spotCheck(input string tag, input logic [5:0] addr, input logic expected);
        rom_counter = addr;
        #1;
        checkOutput(tag, sprite_color, expected);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        row_valid   = 1'b0;
        row_data    = 8'h00;
        frame_sync  = 1'b0;
        rom_counter = 6'd0;
        mdl_flip    = 0;
`ifdef SPRITE_MIRROR_EN
        flip_x      = 1'b0;
`endif
        modelReset();

        // Reset state and default bitmap
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", row_ready, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_swapped", swapped, 1'b0);
        rst_n = 1'b1;
        sweepCheck("default_sweep");
        spotCheck("spot_04", 6'h04, 1'b1);
        spotCheck("spot_00", 6'h00, 1'b0);
        spotCheck("spot_18", 6'h18, 1'b1);

        // Full load of 0xFF rows with valid held high, then swap
        applyStimulus(1, 0, 8'h00, 0);
        for (int r = 0; r < 8; r++) applyStimulus(0, 1, 8'hFF, 0);
        checkOutput("commit_busy", busy, 1'b1);
        checkOutput("commit_ready", row_ready, 1'b0);
        sweepCheck("commit_still_default");
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("swap_pulse", swapped, 1'b1);
        checkOutput("swap_busy", busy, 1'b0);
        sweepCheck("all_ones");
        applyStimulus(0, 0, 8'h00, 0);

        // Gapped valid with rows 0x01..0x08
        applyStimulus(1, 0, 8'h00, 0);
        for (int r = 1; r <= 8; r++) begin
            applyStimulus(0, 0, 8'hEE, 0);
            applyStimulus(0, 1, 8'(r), 0);
        end
        applyStimulus(0, 0, 8'h00, 1);
        for (int y = 0; y < 8; y++)
            spotCheck("row_bit0", 6'(y * 8), (y % 2 == 0) ? 1'b1 : 1'b0);

        // Restart after a partial load, then zeros
        applyStimulus(1, 0, 8'h00, 0);
        for (int r = 0; r < 4; r++) applyStimulus(0, 1, 8'($urandom), 0);
        applyStimulus(1, 1, 8'hFF, 0);
        for (int r = 0; r < 8; r++) applyStimulus(0, 1, 8'h00, 0);
        applyStimulus(1, 0, 8'h00, 1);
        checkOutput("restart_no_swap", swapped, 1'b0);
        for (int r = 0; r < 8; r++) applyStimulus(0, 1, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 1);
        sweepCheck("all_zero");

        // Sync while idle and on the 8th beat must not swap; a later sync does
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("idle_sync", swapped, 1'b0);
        applyStimulus(1, 0, 8'h00, 0);
        for (int r = 0; r < 7; r++) applyStimulus(0, 1, 8'($urandom), 0);
        applyStimulus(0, 1, 8'($urandom), 1);
        checkOutput("eighth_beat_sync", swapped, 1'b0);
        applyStimulus(0, 0, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("late_sync", swapped, 1'b1);
        sweepCheck("random_sprite");

        // Randomized traffic
        for (int i = 0; i < 600; i++)
            applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
                          8'($urandom), $urandom_range(0, 5) == 0);
        sweepCheck("random_end");

        // Reset in the middle of a load
        applyStimulus(1, 0, 8'h00, 0);
        for (int r = 0; r < 3; r++) applyStimulus(0, 1, 8'($urandom), 0);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("midload_reset_ready", row_ready, 1'b0);
        checkOutput("midload_reset_busy", busy, 1'b0);
        sweepCheck("midload_reset_default");
`ifdef SPRITE_MIRROR_EN
        flip_x   = 1'b1;
        mdl_flip = 1;
        spotCheck("mirror_03", 6'h03, 1'b1);
        spotCheck("mirror_04", 6'h04, 1'b0);
        sweepCheck("mirror_sweep");
        flip_x   = 1'b0;
        mdl_flip = 0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 8'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_loader.md
Name: sprite_loader

Overview:
- Writer side of the 8x8 sprite bitmap read by the pixel pipeline: accepts a new sprite one row per valid/ready beat and serves pixels through the existing {y,x} 6-bit counter read port.
- Double-buffered. Rows land in a shadow bank. The active bank swaps only on a frame-sync pulse after a complete 8-row load, so the display never shows a half-written sprite.
- Sits between the host/config logic (ui_in side) and the sprite renderer.

Parameters:
- SPRITE_W, 8, pixels per row (row word width); fixed at 8 for this revision.
- SPRITE_H, 8, rows per sprite; fixed at 8 for this revision.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle pulse; begins (or restarts) a load into the shadow bank
- i_row_valid  in  1  row data valid
- i_row_data  in  8  row bitmap; bit x = pixel x
- o_row_ready  out  1  loader accepts a row this cycle
- i_frame_sync  in  1  single-cycle pulse at vblank; bank-swap point
- o_busy  out  1  high in LOAD or COMMIT
- o_swapped  out  1  one-cycle pulse the cycle after a bank swap
- i_rom_counter  in  6  read address {y[5:3], x[2:0]}
- o_sprite_color  out  1  pixel bit of the active bank

Behaviour:
- Reset (async, rst_n low):
  - Both banks take the default sprite. Rows 0..7 = 01110000, 11110000, 00110000, 00111001, 00111111, 00011110, 00010100, 00010100.
  - Active bank = 0, state = IDLE, row index = 0.
  - o_row_ready = 0, o_busy = 0, o_swapped = 0.
  - Reset mid-load or mid-commit discards everything and restores the defaults.
- Read port:
  - Combinational, zero latency: o_sprite_color = active_bank[y][x].
  - Unaffected by shadow-bank writes.
- FSM states: IDLE, LOAD, COMMIT.
- IDLE:
  - o_row_ready = 0.
  - i_start -> LOAD, row index = 0.
- LOAD:
  - o_row_ready = 1.
  - On i_row_valid & o_row_ready: shadow[row index] <= i_row_data, row index increments.
  - A beat at row index 7 -> COMMIT; row index wraps to 0.
  - i_row_valid low: hold, no write.
- COMMIT:
  - o_row_ready = 0.
  - Waits for i_frame_sync. When it arrives: active bank toggles, o_swapped pulses the next cycle, state -> IDLE.
- i_start during LOAD or COMMIT:
  - Restart: state LOAD, row index 0, partial shadow content discarded, pending swap cancelled.
  - i_start has priority over a same-cycle data beat (the beat is not written) and over a same-cycle i_frame_sync (no swap).
- i_frame_sync outside COMMIT: ignored.
- i_frame_sync in the same cycle as the 8th beat: no swap; the swap needs a later sync pulse while in COMMIT.
- Swap semantics: the new shadow bank is the previously active bank. A following load overwrites old data, so every load must supply all 8 rows.
- o_busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro SPRITE_MIRROR_EN.
- When defined:
  - Adds input port i_flip_x (1 bit).
  - When i_flip_x = 1, o_sprite_color = active_bank[y][7-x] (horizontal mirror, combinational).
  - Loading is unaffected.
- When undefined: port absent; read is always active_bank[y][x].

Test Plan:
- Reset, sweep i_rom_counter 0..63 -> output matches the default bitmap. Spot checks: addr 0x04 (y0, x4) = 1, addr 0x00 = 0, addr 0x18 (y3, x0) = 1.
- i_start, then 8 rows of 0xFF with valid held high -> o_row_ready high 8 cycles, then COMMIT with o_busy = 1. Read still shows the default sprite. i_frame_sync -> next cycle o_swapped = 1, all 64 reads = 1, o_busy = 0.
- Valid toggled every other cycle during a load of rows 0x01..0x08 -> exactly 8 writes. After swap, addr y*8 (x = 0) returns row bit 0 (1,0,1,0,1,0,1,0 for y 0..7).
- 4 rows accepted, then i_start, then 8 rows 0x00, then sync -> all reads 0. No swap occurs before the sync.
- i_frame_sync while IDLE, and in the same cycle as the 8th beat -> no swap, no o_swapped. A later sync in COMMIT swaps.
- With SPRITE_MIRROR_EN and i_flip_x = 1 after reset -> addr 0x03 (y0, x3 -> bit 4) = 1, addr 0x04 (bit 3) = 0. Assert rst_n low mid-load -> defaults restored immediately, o_row_ready = 0.
